// File: rtl/ddr_pmon_freqdet_mc.sv
// Multi-channel frequency monitor: counts synchronised toggle edges per channel over a
// programmable i_clk window and qualifies each count against target +/- range for lock.

module ddr_demet_r (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_ff1, r_ff2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;
endmodule

module ddr_pmon_freqdet_ch #(
    parameter int CNT_W = 24,
    parameter int RNG_W = 10,
    parameter int LCK_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tog,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cnt_en,
    input  logic             i_win_end,
    input  logic [CNT_W-1:0] i_cmp,
    input  logic [RNG_W-1:0] i_range,
    input  logic [LCK_W-1:0] i_lock_thr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_pass,
    output logic             o_lock,
    output logic             o_lost
);
    // Bounds are computed one bit wider than either operand so neither end can wrap.
    localparam int EW = ((CNT_W > RNG_W) ? CNT_W : RNG_W) + 1;

    logic             w_sync, r_ff3, w_event, w_pass;
    logic [CNT_W-1:0] r_cnt, w_fin;
    logic [CNT_W:0]   w_sum;
    logic [EW-1:0]    w_cmp_e, w_rng_e, w_cnt_e, w_max, w_lo, w_hi;
    logic [LCK_W-1:0] r_lck, w_thr, w_lck_nxt;

    ddr_demet_r u_demet (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_tog), .o_q(w_sync));

    assign w_event = w_sync ^ r_ff3;
    assign w_sum   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_event};
    assign w_fin   = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    assign w_cmp_e = EW'(i_cmp);
    assign w_rng_e = EW'(i_range);
    assign w_cnt_e = EW'(w_fin);
    assign w_max   = EW'({CNT_W{1'b1}});
    assign w_lo    = (w_cmp_e > w_rng_e) ? (w_cmp_e - w_rng_e) : '0;
    assign w_hi    = ((w_cmp_e + w_rng_e) > w_max) ? w_max : (w_cmp_e + w_rng_e);
    assign w_pass  = (w_cnt_e >= w_lo) && (w_cnt_e <= w_hi);

    assign w_thr     = (i_lock_thr == '0) ? LCK_W'(1) : i_lock_thr;
    assign w_lck_nxt = !w_pass ? '0 : ((r_lck >= w_thr) ? w_thr : (r_lck + LCK_W'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ff3   <= 1'b0;
            r_cnt   <= '0;
            r_lck   <= '0;
            o_count <= '0;
            o_pass  <= 1'b0;
            o_lock  <= 1'b0;
            o_lost  <= 1'b0;
        end else begin
            r_ff3 <= w_sync;
            if (!i_cnt_en || i_win_end)
                r_cnt <= '0;
            else
                r_cnt <= w_fin;

            if (i_start) begin
                r_lck  <= '0;
                o_lock <= 1'b0;
                o_lost <= 1'b0;
            end else if (i_abort) begin
                o_lock <= 1'b0;
            end else if (i_win_end) begin
                o_count <= w_fin;
                o_pass  <= w_pass;
                r_lck   <= w_lck_nxt;
                o_lock  <= (w_lck_nxt >= w_thr);
                o_lost  <= o_lost | (o_lock & ~w_pass);
            end
        end
    end
endmodule

module ddr_pmon_freqdet_mc #(
    parameter int NUM_CH = 2,
    parameter int WIN_W  = 16,
    parameter int CNT_W  = 24,
    parameter int RNG_W  = 10,
    parameter int LCK_W  = 4,
    parameter int SETTLE = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_mode,
    input  logic [WIN_W-1:0]        i_win,
    input  logic [NUM_CH-1:0]       i_tog,
    input  logic [NUM_CH*CNT_W-1:0] i_cmp,
    input  logic [RNG_W-1:0]        i_range,
    input  logic [LCK_W-1:0]        i_lock_thr,
    output logic [NUM_CH*CNT_W-1:0] o_count,
    output logic [NUM_CH-1:0]       o_pass,
    output logic [NUM_CH-1:0]       o_lock,
    output logic [NUM_CH-1:0]       o_lost,
    output logic                    o_win_pulse,
    output logic                    o_done
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_HOLD} state_t;

    localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           r_state;
    logic             r_en_q, r_mode;
    logic [SET_W-1:0] r_set_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic             w_start, w_cnt_en, w_win_end;

    // en_q resets high so an i_en already high across reset is not taken as a rise.
    assign w_start   = i_en & ~r_en_q & (r_state == S_IDLE);
    assign w_cnt_en  = i_en & (r_state == S_COUNT);
    assign w_win_end = w_cnt_en & (r_win_cnt == i_win);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_en_q      <= 1'b1;
            r_mode      <= 1'b0;
            r_set_cnt   <= '0;
            r_win_cnt   <= '0;
            o_win_pulse <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_en_q      <= i_en;
            o_win_pulse <= 1'b0;
            if (!i_en) begin
                r_state   <= S_IDLE;
                r_set_cnt <= '0;
                r_win_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_mode    <= i_mode;
                        o_done    <= 1'b0;
                        r_set_cnt <= '0;
                        r_state   <= S_SETTLE;
                    end
                    S_SETTLE: if (r_set_cnt == SET_W'(SET_LAST)) begin
                        r_win_cnt <= '0;
                        r_state   <= S_COUNT;
                    end else begin
                        r_set_cnt <= r_set_cnt + SET_W'(1);
                    end
                    S_COUNT: if (w_win_end) begin
                        r_win_cnt   <= '0;
                        o_win_pulse <= 1'b1;
                        o_done      <= 1'b1;
                        if (!r_mode)
                            r_state <= S_HOLD;
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                    end
                    default: r_state <= S_HOLD;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ddr_pmon_freqdet_ch #(.CNT_W(CNT_W), .RNG_W(RNG_W), .LCK_W(LCK_W)) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_tog      (i_tog[k]),
            .i_start    (w_start),
            .i_abort    (~i_en),
            .i_cnt_en   (w_cnt_en),
            .i_win_end  (w_win_end),
            .i_cmp      (i_cmp[k*CNT_W +: CNT_W]),
            .i_range    (i_range),
            .i_lock_thr (i_lock_thr),
            .o_count    (o_count[k*CNT_W +: CNT_W]),
            .o_pass     (o_pass[k]),
            .o_lock     (o_lock[k]),
            .o_lost     (o_lost[k])
        );
    end
endmodule

// File: tb/tb_ddr_pmon_freqdet_mc.sv
// Bench for ddr_pmon_freqdet_mc: a 2-channel instance against a window/event model,
// plus an 8-bit-count instance for saturation corners.

module tb_ddr_pmon_freqdet_mc;
    localparam int MAXC = (1 << 24) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, mode;
    logic [15:0] win;
    logic [1:0]  tog = '0;
    logic [47:0] cmp;
    logic [9:0]  rng;
    logic [3:0]  thr;
    logic [47:0] o_count;
    logic [1:0]  o_pass, o_lock, o_lost;
    logic        o_win_pulse, o_done;

    logic        en_b, mode_b, tog_b = 1'b0;
    logic [15:0] win_b;
    logic [7:0]  cmp_b, cnt_b;
    logic [9:0]  rng_b;
    logic [3:0]  thr_b;
    logic        pass_b, lock_b, lost_b, pulse_b, done_b;

    int n_chk = 0, n_err = 0;
    int per[2] = '{0, 0};
    int ph[2]  = '{0, 0};
    bit fast_b = 1'b0;

    ddr_pmon_freqdet_mc dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_win(win), .i_tog(tog),
        .i_cmp(cmp), .i_range(rng), .i_lock_thr(thr), .o_count(o_count), .o_pass(o_pass),
        .o_lock(o_lock), .o_lost(o_lost), .o_win_pulse(o_win_pulse), .o_done(o_done));

    ddr_pmon_freqdet_mc #(.NUM_CH(1), .CNT_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_mode(mode_b), .i_win(win_b), .i_tog(tog_b),
        .i_cmp(cmp_b), .i_range(rng_b), .i_lock_thr(thr_b), .o_count(cnt_b), .o_pass(pass_b),
        .o_lock(lock_b), .o_lost(lost_b), .o_win_pulse(pulse_b), .o_done(done_b));

    always #5 clk = ~clk;

    // Toggle sources: per>0 flips every per clocks, per<0 flips at random, per==0 holds.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (per[k] < 0) begin
                if ($urandom_range(0, 1) == 1) tog[k] = ~tog[k];
            end else if (per[k] > 0) begin
                ph[k]++;
                if (ph[k] >= per[k]) begin
                    ph[k] = 0;
                    tog[k] = ~tog[k];
                end
            end
        end
        if (fast_b) tog_b = ~tog_b;
    end

    // Reference model: an input change sampled at edge t is counted at edge t+2 if that
    // edge lies in a window; windows start 5 edges after the enable-rise edge.
    bit sh1[2], sh2[2], sh3[2], ev[2];
    int acc[2], lkc[2], e_count[2];
    bit e_pass[2], e_lock[2], e_lost[2];
    bit e_done, e_pulse, m_en_prev, m_hold, m_mode;
    int m_rel;
    int c, lo, hi, t;
    bit p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sh1[k] = 0; sh2[k] = 0; sh3[k] = 0; acc[k] = 0; lkc[k] = 0;
                e_count[k] = 0; e_pass[k] = 0; e_lock[k] = 0; e_lost[k] = 0;
            end
            m_rel = -1; m_en_prev = 1; m_hold = 0; m_mode = 0; e_done = 0; e_pulse = 0;
        end else begin
            e_pulse = 0;
            for (int k = 0; k < 2; k++) begin
                ev[k] = sh2[k] ^ sh3[k];
                sh3[k] = sh2[k]; sh2[k] = sh1[k]; sh1[k] = tog[k];
            end
            if (!en) begin
                m_rel = -1; m_hold = 0;
                e_lock[0] = 0; e_lock[1] = 0;
            end else if (m_rel < 0) begin
                if (!m_en_prev) begin
                    m_rel = 0; m_hold = 0; m_mode = mode; e_done = 0;
                    for (int k = 0; k < 2; k++) begin
                        acc[k] = 0; lkc[k] = 0; e_lock[k] = 0; e_lost[k] = 0;
                    end
                end
            end else if (!m_hold) begin
                m_rel++;
                if (m_rel >= 5) begin
                    for (int k = 0; k < 2; k++) acc[k] += int'(ev[k]);
                    if ((m_rel - 5) % (int'(win) + 1) == int'(win)) begin
                        for (int k = 0; k < 2; k++) begin
                            c  = (acc[k] > MAXC) ? MAXC : acc[k];
                            lo = int'(cmp[k*24 +: 24]) - int'(rng);
                            if (lo < 0) lo = 0;
                            hi = int'(cmp[k*24 +: 24]) + int'(rng);
                            if (hi > MAXC) hi = MAXC;
                            p  = (c >= lo) && (c <= hi);
                            t  = (thr == 0) ? 1 : int'(thr);
                            lkc[k] = p ? ((lkc[k] + 1 > t) ? t : lkc[k] + 1) : 0;
                            e_lost[k] = e_lost[k] | (e_lock[k] & !p);
                            e_lock[k] = (lkc[k] >= t);
                            e_count[k] = c;
                            e_pass[k] = p;
                            acc[k] = 0;
                        end
                        e_pulse = 1; e_done = 1;
                        if (!m_mode) m_hold = 1;
                    end
                end
            end
            m_en_prev = en;
        end
    end

    int np_dut = 0, np_mod = 0;
    always @(negedge clk) begin
        if (!rst) begin
            np_dut += int'(o_win_pulse);
            np_mod += int'(e_pulse);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_count%0d", tag, k), 32'(o_count[k*24 +: 24]), e_count[k]);
            chk($sformatf("%s_pass%0d", tag, k), 32'(o_pass[k]), 32'(e_pass[k]));
            chk($sformatf("%s_lock%0d", tag, k), 32'(o_lock[k]), 32'(e_lock[k]));
            chk($sformatf("%s_lost%0d", tag, k), 32'(o_lost[k]), 32'(e_lost[k]));
        end
        chk({tag, "_done"}, 32'(o_done), 32'(e_done));
        chk({tag, "_pulse"}, 32'(o_win_pulse), 32'(e_pulse));
        chk({tag, "_tally"}, np_dut, np_mod);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, 32'(o_count[23:0]) | 32'(o_count[47:24]), 0);
        chk({tag, "_flags"}, 32'({o_pass, o_lock, o_lost, o_win_pulse, o_done}), 0);
        chk({tag, "_count_b"}, 32'(cnt_b), 0);
        chk({tag, "_flags_b"}, 32'({pass_b, lock_b, lost_b, pulse_b, done_b}), 0);
    endtask

    task automatic wait_pulse(input string tag, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (o_win_pulse !== 1'b1 && n < bound);
        chk({tag, "_pulse_seen"}, 32'(o_win_pulse), 1);
    endtask

    task automatic start_wait(input string tag, input int bound, output int n);
        @(negedge clk); en = 1'b1;
        wait_pulse(tag, bound, n);
    endtask

    task automatic wait_pulse_b(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (pulse_b !== 1'b1 && n < 1100);
        chk({tag, "_pulse_seen"}, 32'(pulse_b), 1);
    endtask

    initial begin
        int n, base;
        rst = 1'b1; en = 1'b0; mode = 1'b0; win = 16'd99; cmp = '0; rng = '0; thr = '0;
        en_b = 1'b0; mode_b = 1'b0; win_b = 16'd999; cmp_b = '0; rng_b = '0; thr_b = 4'd1;
        repeat (3) @(posedge clk);
        #1 chk_zero("rst");
        @(negedge clk) rst = 1'b0;

        // One-shot nominal
        per[0] = 2; per[1] = 3; cmp = {24'd33, 24'd50}; rng = 10'd2; thr = 4'd1;
        repeat (10) @(negedge clk);
        base = np_dut;
        start_wait("os", 130, n);
        chk("os_latency", n, 105);
        chk_all("os");
        chk("os_window0", 32'(o_count[23:0] >= 24'd49 && o_count[23:0] <= 24'd51), 1);
        chk("os_pass0", 32'(o_pass[0]), 1);
        repeat (300) @(posedge clk);
        #1 chk("os_single_pulse", np_dut, base + 1);
        chk_all("os_hold");

        // Continuous lock then loss
        @(negedge clk) en = 1'b0;
        mode = 1'b1; thr = 4'd3;
        repeat (3) @(negedge clk);
        start_wait("ll1", 130, n);
        chk_all("ll1");
        wait_pulse("ll2", 110, n);
        chk_all("ll2");
        chk("ll2_nolock0", 32'(o_lock[0]), 0);
        wait_pulse("ll3", 110, n);
        chk_all("ll3");
        chk("ll3_lock0", 32'(o_lock[0]), 1);
        per[0] = 4;
        wait_pulse("ll4", 110, n);
        chk_all("ll4");
        chk("ll4_lost0", 32'({o_pass[0], o_lock[0], o_lost[0]}), 32'(3'b001));
        per[0] = 2;
        wait_pulse("ll5", 110, n);
        chk_all("ll5");
        wait_pulse("ll6", 110, n);
        chk_all("ll6");
        chk("ll6_lost_sticky", 32'({o_pass[0], o_lost[0]}), 32'(2'b11));

        // Abort mid-window, then a fresh one-shot
        repeat (50) @(posedge clk);
        @(negedge clk) en = 1'b0;
        base = np_dut;
        repeat (60) @(posedge clk);
        #1 chk_all("abort");
        chk("abort_nopulse", np_dut, base);
        chk("abort_nolock", 32'(o_lock), 0);
        mode = 1'b0;
        start_wait("reen", 130, n);
        chk("reen_latency", n, 105);
        chk_all("reen");

        // Multi-channel independence
        @(negedge clk) en = 1'b0;
        win = 16'd599; cmp = {24'd200, 24'd300}; rng = 10'd3; thr = 4'd1;
        repeat (3) @(negedge clk);
        start_wait("mc", 640, n);
        chk("mc_latency", n, 605);
        chk_all("mc");
        chk("mc_near0", 32'(o_count[23:0] >= 24'd298 && o_count[23:0] <= 24'd302), 1);
        chk("mc_near1", 32'(o_count[47:24] >= 24'd198 && o_count[47:24] <= 24'd202), 1);

        // Randomised one-shot windows
        for (int it = 0; it < 4; it++) begin
            @(negedge clk) en = 1'b0;
            win = 16'($urandom_range(20, 200));
            per[0] = int'($urandom_range(0, 5)) - 1;
            per[1] = int'($urandom_range(0, 5)) - 1;
            cmp = {24'($urandom_range(0, 100)), 24'($urandom_range(0, 100))};
            rng = 10'($urandom_range(0, 30));
            thr = 4'($urandom_range(0, 2));
            repeat (3) @(negedge clk);
            start_wait($sformatf("rnd%0d", it), int'(win) + 30, n);
            chk($sformatf("rnd%0d_latency", it), n, int'(win) + 6);
            chk_all($sformatf("rnd%0d", it));
        end

        // Saturation on the 8-bit instance
        fast_b = 1'b1; cmp_b = 8'd0; rng_b = 10'd5;
        @(negedge clk) en_b = 1'b1;
        wait_pulse_b("sat_lo");
        chk("sat_lo_count", 32'(cnt_b), 255);
        chk("sat_lo_flags", 32'({pass_b, lock_b, done_b}), 32'(3'b001));
        @(negedge clk) en_b = 1'b0;
        cmp_b = 8'd250; rng_b = 10'd10;
        repeat (3) @(negedge clk);
        en_b = 1'b1;
        wait_pulse_b("sat_hi");
        chk("sat_hi_count", 32'(cnt_b), 255);
        chk("sat_hi_flags", 32'({pass_b, lock_b, done_b}), 32'(3'b111));

        // Asynchronous reset mid-COUNT with i_en held high
        @(negedge clk) en = 1'b0;
        win = 16'd99; mode = 1'b1; per[0] = 2; per[1] = 3; cmp = {24'd33, 24'd50};
        rng = 10'd2; thr = 4'd1;
        repeat (3) @(negedge clk);
        start_wait("pre_rst", 130, n);
        repeat (30) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        base = np_dut;
        repeat (200) @(posedge clk);
        #1 chk("rst_nostart", np_dut, base);
        chk_all("rst_idle");
        @(negedge clk) en = 1'b0;
        repeat (3) @(negedge clk);
        start_wait("post_rst", 130, n);
        chk("post_rst_latency", n, 105);
        chk_all("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
